// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, parity modes, parity helper.
package uart_pkg;

  localparam int unsigned UART_MAX_DATA_W = 9;

  localparam logic UART_PAR_EVEN = 1'b0;
  localparam logic UART_PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } uart_tx_state_t;

  // Parity bit over a zero-extended data word; zero padding does not change XOR.
  function automatic logic uart_parity(input logic [UART_MAX_DATA_W-1:0] data,
                                       input logic                       odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; head is visible on dout.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     txclk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [LW-1:0]    level_nxt;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this edge, used to register the flags
  always_comb begin
    level_nxt = level + LW'(push_ok) - LW'(pop_ok);
  end

  // Pointers, level and flags
  always_ff @(posedge txclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge txclk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with a queued TX FIFO and status flags.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                          txclk,
  input  logic                          reset,
  input  logic                          ld_tx_data,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_enable,
  input  logic                          clr_over_run,
  output logic                          tx_out,
  output logic                          tx_empty,
  output logic                          tx_full,
  output logic                          tx_busy,
  output logic                          tx_over_run,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_MODE   = (PARITY_ODD != 0) ? UART_PAR_ODD : UART_PAR_EVEN;
  localparam logic              HAS_PARITY = (PARITY_EN != 0);

  uart_tx_state_t    state;
  uart_tx_state_t    state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              par_bit;
  logic              par_nxt;
  logic              tx_out_nxt;
  logic              tx_busy_nxt;
  logic              tx_empty_nxt;
  logic              over_run_nxt;
  logic              bit_done;
  logic              pop_c;
  logic              fifo_push;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [LVL_W-1:0]  lvl_nxt;

  assign bit_done  = (baud_cnt == BAUD_LAST);
  assign fifo_push = ld_tx_data & ~tx_full;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .txclk (txclk),
    .reset (reset),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (fifo_empty),
    .level (tx_level)
  );

  // FSM state register
  always_ff @(posedge txclk) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a pop happens whenever a frame is launched
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_nxt = TX_START;
          pop_c     = 1'b1;
        end
      end
      TX_START: begin
        if (bit_done) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (bit_done && (bit_cnt == DATA_LAST)) state_nxt = HAS_PARITY ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        if (bit_done) state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (bit_done && (bit_cnt == STOP_LAST)) begin
          if (tx_enable && !fifo_empty) begin
            state_nxt = TX_START;
            pop_c     = 1'b1;
          end else begin
            state_nxt = TX_IDLE;
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Datapath and output next values, derived from the state being entered
  always_comb begin
    baud_nxt     = baud_cnt;
    bit_nxt      = bit_cnt;
    shreg_nxt    = shreg;
    par_nxt      = par_bit;
    tx_out_nxt   = 1'b1;
    tx_busy_nxt  = 1'b0;
    tx_empty_nxt = 1'b0;
    over_run_nxt = tx_over_run;
    lvl_nxt      = tx_level + LVL_W'(fifo_push) - LVL_W'(pop_c);

    if (state == TX_IDLE || bit_done) baud_nxt = '0;
    else                              baud_nxt = baud_cnt + BAUD_W'(1);

    if ((state == TX_DATA || state == TX_STOP) && bit_done) bit_nxt = bit_cnt + BIT_W'(1);
    if (state_nxt != state) bit_nxt = '0;

    if (state == TX_DATA && bit_done) shreg_nxt = shreg >> 1;
    if (pop_c) begin
      shreg_nxt = fifo_dout;
      par_nxt   = uart_parity(UART_MAX_DATA_W'(fifo_dout), PAR_MODE);
    end

    case (state_nxt)
      TX_START:  tx_out_nxt = 1'b0;
      TX_DATA:   tx_out_nxt = shreg_nxt[0];
      TX_PARITY: tx_out_nxt = par_nxt;
      default:   tx_out_nxt = 1'b1;
    endcase

    tx_busy_nxt  = (state_nxt != TX_IDLE);
    tx_empty_nxt = (state_nxt == TX_IDLE) && (lvl_nxt == '0);

    // An overflowing write takes priority over a clear in the same cycle
    if (ld_tx_data && tx_full) over_run_nxt = 1'b1;
    else if (clr_over_run)     over_run_nxt = 1'b0;
  end

  // Datapath and registered outputs
  always_ff @(posedge txclk) begin
    if (reset) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      tx_out      <= 1'b1;
      tx_busy     <= 1'b0;
      tx_empty    <= 1'b1;
      tx_over_run <= 1'b0;
    end else begin
      baud_cnt    <= baud_nxt;
      bit_cnt     <= bit_nxt;
      shreg       <= shreg_nxt;
      par_bit     <= par_nxt;
      tx_out      <= tx_out_nxt;
      tx_busy     <= tx_busy_nxt;
      tx_empty    <= tx_empty_nxt;
      tx_over_run <= over_run_nxt;
    end
  end

endmodule

// File: doc/uart_tx_fifo_param.md
# uart_tx_fifo_param

Parametrised UART transmitter, successor to the fixed 8N1 TX path. Configurable data width, parity, stop bits and baud divider, with an internal transmit FIFO so the host can queue bytes while a frame is in flight. Sits between the host register interface and the serial pin in the same `txclk` domain. Flags overrun, empty, full and fill level.

## Interface
- `DATA_W`, 8, data bits per frame; legal 5..9.
- `CLKS_PER_BIT`, 16, `txclk` cycles per serial bit; legal ≥ 2.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of 2, ≥ 2.
- `PARITY_EN`, 0, 1 adds a parity bit after the data bits.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1, 1 or 2.

Ports:
- `txclk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_tx_data` in 1: write strobe; pushes `tx_data` into the FIFO.
- `tx_data` in `DATA_W`: write data.
- `tx_enable` in 1: permits starting new frames.
- `clr_over_run` in 1: clears `tx_over_run`.
- `tx_out` out 1: serial line; idle high.
- `tx_empty` out 1: FIFO empty and FSM in IDLE.
- `tx_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `tx_busy` out 1: FSM not in IDLE.
- `tx_over_run` out 1: sticky; a write was dropped.
- `tx_level` out clog2(`FIFO_DEPTH`)+1: FIFO occupancy.

## Operation
- Reset values: `tx_out`=1, `tx_empty`=1, `tx_full`=0, `tx_busy`=0, `tx_over_run`=0, `tx_level`=0.
- Reset clears the FIFO pointers and forces the FSM to IDLE.
- Reset mid-frame aborts the frame. `tx_out`=1 from the reset edge.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
- IDLE: if `tx_enable`=1 and the FIFO is non-empty, pop the head into the shift register and go to START.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles.
- DATA: `DATA_W` bits, LSB first, each `CLKS_PER_BIT` cycles.
- PARITY: entered only when `PARITY_EN`=1. Bit value is XOR of the data (even) or its inverse (odd).
- STOP: `tx_out`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
- At the end of STOP: if `tx_enable`=1 and the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- `tx_enable` falling mid-frame: the current frame completes normally, and no further frame starts.
- Counters:
  - Baud counter: clog2(`CLKS_PER_BIT`) bits; reloads at 0 on each bit boundary.
  - Bit counter: counts data bits 0..`DATA_W`-1, then stop bits 0..`STOP_BITS`-1.
- Write while `tx_full`=1: data dropped, `tx_over_run`←1. This holds even if a pop occurs in the same cycle.
- Write and pop in the same cycle, not full: both occur and `tx_level` is unchanged.
- `clr_over_run` and an overflowing write in the same cycle: set wins.

## Timing
- All outputs are registered.
- `ld_tx_data` sampled at edge E0 with the FIFO empty, FSM in IDLE and `tx_enable`=1:
  - After E0: `tx_level`=1 and `tx_empty`=0.
  - At E1: pop; START begins and `tx_out`=0; `tx_busy`=1.
- Frame length is (1 + `DATA_W` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `tx_empty` rises at the edge ending the last stop cycle, provided the FIFO is empty.
- `tx_full`, `tx_level` and `tx_over_run` update on the edge after the write or pop.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_tx_state_t`.
  - Parity-mode constants.
  - Function `uart_parity(data, odd)`.
- Sub-module `uart_sync_fifo`: single-clock FIFO.
  - Parameters: width, depth.
  - Ports: push, pop, dout, full, empty, level.
  - Reset behaviour: synchronous, same as this block.
- Top-level module contains the FSM, baud counter, shifter and flag logic.

## Test plan
- Bench configuration for all scenarios: `DATA_W`=8, `CLKS_PER_BIT`=4.
- 8N1, write 0xA5 → `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total). `tx_empty` returns to 1 at cycle 41.
- 8E1 with 0xA5 → parity bit 0. 8O2 with 0xA5 → parity bit 1, then stop held high for 8 cycles; frame is 48 cycles.
- `FIFO_DEPTH`=4, `tx_enable`=0, write 0x01..0x05 → `tx_level`=4, `tx_full`=1, `tx_over_run`=1. Then raise `tx_enable` → frames 0x01..0x04 back-to-back with no idle cycles; 0x05 never sent.
- Drop `tx_enable` during the DATA bits of frame 1, with 2 entries queued → frame 1 completes. `tx_out` stays 1 and `tx_level` stays 2.
- Assert `reset` at cycle 10 of a frame → `tx_out`=1, `tx_level`=0, `tx_busy`=0 after the reset edge. A new write after reset transmits cleanly.
- Pulse `clr_over_run` with no overflow → `tx_over_run` 1→0. Simultaneous clear and overflow → `tx_over_run` stays 1.
